// File: rtl/stc_pkg.sv
// Shared widths and types for the sphere_to_cart quadrilateral area estimator.
package stc_pkg;

    localparam int unsigned RADIUS_W = 16;
    localparam int unsigned AREA_W   = 26;
    localparam int unsigned N_SLOTS  = 4;
    localparam int unsigned PROD_W   = 2 * (RADIUS_W + 1);

    localparam logic [AREA_W-1:0] AREA_MAX = {AREA_W{1'b1}};

    typedef logic [RADIUS_W-1:0] radius_t;
    typedef logic [AREA_W-1:0]   area_t;
    typedef logic [PROD_W-1:0]   prod_t;

endpackage

// File: rtl/stc_half_sat.sv
// Halves the cross-product sum and fits it into the area width.
// STC_AREA_SATURATE_EN clamps to all-ones on overflow; otherwise upper bits are dropped.
module stc_half_sat #(
    parameter int unsigned PROD_W = stc_pkg::PROD_W,
    parameter int unsigned AREA_W = stc_pkg::AREA_W
) (
    input  logic [PROD_W-1:0] prod_i,
    output logic [AREA_W-1:0] area_o
);

`ifdef STC_AREA_SATURATE_EN
    logic unused_lsb;
    assign unused_lsb = prod_i[0];

    always_comb begin
        area_o = prod_i[AREA_W:1];
        if (|prod_i[PROD_W-1:AREA_W+1]) begin
            area_o = {AREA_W{1'b1}};
        end
    end
`else
    logic unused_bits;
    assign unused_bits = ^{prod_i[PROD_W-1:AREA_W+1], prod_i[0]};

    always_comb begin
        area_o = prod_i[AREA_W:1];
    end
`endif

endmodule

// File: rtl/sphere_to_cart.sv
// Collects 4 radii at 90-degree spacing and reports the spanned quadrilateral area.
// Two-stage pipeline after the frame's last sample; overflow handling set by STC_AREA_SATURATE_EN.
module sphere_to_cart #(
    parameter int unsigned RADIUS_W = stc_pkg::RADIUS_W,
    parameter int unsigned AREA_W   = stc_pkg::AREA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [RADIUS_W-1:0] radius,
    output logic [AREA_W-1:0]   area,
    output logic                rdy
);

    import stc_pkg::*;

    localparam int unsigned SumW  = RADIUS_W + 1;
    localparam int unsigned ProdW = 2 * SumW;

    logic [1:0]          slot_q;
    logic [RADIUS_W-1:0] r_q [N_SLOTS];
    logic                frame_q;
    logic                v1_q;
    logic [ProdW-1:0]    s_q;
    logic [ProdW-1:0]    s_d;
    logic [SumW-1:0]     sum_a;
    logic [SumW-1:0]     sum_b;
    logic [AREA_W-1:0]   area_d;
    logic [AREA_W-1:0]   area_q;
    logic                rdy_q;

    // Opposite radii pair up: (r0+r2)(r1+r3) expands to the four adjacent products.
    always_comb begin
        sum_a = SumW'(r_q[0]) + SumW'(r_q[2]);
        sum_b = SumW'(r_q[1]) + SumW'(r_q[3]);
        s_d   = ProdW'(sum_a) * ProdW'(sum_b);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q  <= 2'd0;
            frame_q <= 1'b0;
            for (int i = 0; i < N_SLOTS; i++) begin
                r_q[i] <= '0;
            end
        end else begin
            frame_q <= en && (slot_q == 2'd3);
            if (en) begin
                r_q[slot_q] <= radius;
                slot_q      <= slot_q + 2'd1;
            end
        end
    end

    // Stage 1 samples the frame on the edge after slot 3, before a new slot 0 can land.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q  <= '0;
            v1_q <= 1'b0;
        end else begin
            v1_q <= frame_q;
            if (frame_q) begin
                s_q <= s_d;
            end
        end
    end

    stc_half_sat #(
        .PROD_W (ProdW),
        .AREA_W (AREA_W)
    ) u_half_sat (
        .prod_i (s_q),
        .area_o (area_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            area_q <= '0;
            rdy_q  <= 1'b0;
        end else begin
            rdy_q <= v1_q;
            if (v1_q) begin
                area_q <= area_d;
            end
        end
    end

    assign area = area_q;
    assign rdy  = rdy_q;

endmodule

// File: tb/tb_sphere_to_cart.sv
// Directed self-checking bench for sphere_to_cart.
module tb_sphere_to_cart;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] radius;
    logic [25:0] area;
    logic        rdy;

    int unsigned n_checks;
    int unsigned n_pass;

`ifdef STC_AREA_SATURATE_EN
    localparam logic [25:0] BigArea = 26'd67108863;
`else
    localparam logic [25:0] BigArea = 26'd66846722;
`endif

    sphere_to_cart dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .radius (radius),
        .area   (area),
        .rdy    (rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive inputs, take one rising edge, then settle 1 time unit before sampling.
    task automatic cyc(input logic e, input logic [15:0] r);
        en     = e;
        radius = r;
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d,
                         input logic [25:0] exp);
        cyc(1'b1, a);
        cyc(1'b1, b);
        cyc(1'b1, c);
        cyc(1'b1, d);
        chk({tag, "_rdy_t0"}, 32'(rdy), 32'd0);
        cyc(1'b0, 16'd0);
        chk({tag, "_rdy_t1"}, 32'(rdy), 32'd0);
        cyc(1'b0, 16'd0);
        chk({tag, "_rdy_t2"}, 32'(rdy), 32'd1);
        chk({tag, "_area"}, 32'(area), 32'(exp));
        cyc(1'b0, 16'd0);
        chk({tag, "_rdy_t3"}, 32'(rdy), 32'd0);
        chk({tag, "_hold"}, 32'(area), 32'(exp));
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        en       = 1'b0;
        radius   = 16'd0;

        // Reset state
        @(posedge clk);
        #1;
        chk("reset_area", 32'(area), 32'd0);
        chk("reset_rdy", 32'(rdy), 32'd0);
        rst = 1'b0;

        // Continuous 5000s; en drops after the third frame without stalling it
        for (int i = 1; i <= 14; i++) begin
            cyc(i <= 12, 16'd5000);
            chk($sformatf("cont_rdy_%0d", i), 32'(rdy),
                32'((i == 6) || (i == 10) || (i == 14)));
            if (i == 6 || i == 10 || i == 14) begin
                chk($sformatf("cont_area_%0d", i), 32'(area), 32'd50000000);
            end
        end

        frame("f1234", 16'd1, 16'd2, 16'd3, 16'd4, 26'd12);
        frame("f1100", 16'd1, 16'd1, 16'd0, 16'd0, 26'd0);
        frame("f3111", 16'd3, 16'd1, 16'd1, 16'd1, 26'd4);
        frame("fmax", 16'd65535, 16'd65535, 16'd65535, 16'd65535, BigArea);

        // Alternating en; disabled-cycle radii must be ignored: (10+30)*(20+40)/2
        cyc(1'b1, 16'd10);
        cyc(1'b0, 16'd999);
        cyc(1'b1, 16'd20);
        cyc(1'b0, 16'd999);
        cyc(1'b1, 16'd30);
        cyc(1'b0, 16'd999);
        cyc(1'b1, 16'd40);
        chk("tog_rdy_t0", 32'(rdy), 32'd0);
        cyc(1'b0, 16'd777);
        chk("tog_rdy_t1", 32'(rdy), 32'd0);
        cyc(1'b0, 16'd777);
        chk("tog_rdy_t2", 32'(rdy), 32'd1);
        chk("tog_area", 32'(area), 32'd1200);

        // Partial frame discarded by reset
        cyc(1'b1, 16'd9999);
        cyc(1'b1, 16'd9999);
        rst = 1'b1;
        #1;
        chk("midrst_area", 32'(area), 32'd0);
        chk("midrst_rdy", 32'(rdy), 32'd0);
        cyc(1'b0, 16'd0);
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            cyc(i <= 4, 16'd5000);
            chk($sformatf("postrst_rdy_%0d", i), 32'(rdy), 32'd0);
        end
        cyc(1'b0, 16'd0);
        chk("postrst_rdy_6", 32'(rdy), 32'd1);
        chk("postrst_area", 32'(area), 32'd50000000);

        // Reset one cycle after frame completion drops the in-flight result
        cyc(1'b1, 16'd1);
        cyc(1'b1, 16'd2);
        cyc(1'b1, 16'd3);
        cyc(1'b1, 16'd4);
        cyc(1'b0, 16'd0);
        rst = 1'b1;
        #1;
        chk("flight_rst_area", 32'(area), 32'd0);
        chk("flight_rst_rdy", 32'(rdy), 32'd0);
        cyc(1'b0, 16'd0);
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b0, 16'd0);
            chk($sformatf("flight_drop_rdy_%0d", i), 32'(rdy), 32'd0);
            chk($sformatf("flight_drop_area_%0d", i), 32'(area), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
